// File: rtl/arm_hazard_pkg.sv
// rtl/arm_hazard_pkg.sv - shared types and default parameters for the ARM hazard unit
package arm_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  localparam int RA_W_DEF    = 4;
  localparam int PC_REG_DEF  = 15;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/arm_hazard_unit_sat_counter.sv
// rtl/arm_hazard_unit_sat_counter.sv - saturating up-counter for hazard performance events
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/arm_hazard_unit.sv
// rtl/arm_hazard_unit.sv - forwarding, stall/flush and dmem wait control for the 5-stage ARM core
module arm_hazard_unit
  import arm_hazard_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter int PC_REG  = PC_REG_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int              WC_W   = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);
  localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

  mem_state_t      state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  fwd_sel_t        fwd_a, fwd_b;
  logic            ldr_stall, pc_wr_pend, mem_wait, timeout;

  always_comb begin
    fwd_a = FWD_RF;
    if (RA1E != PC_IDX) begin
      if (RegWriteM && (WA3M == RA1E))      fwd_a = FWD_M;
      else if (RegWriteW && (WA3W == RA1E)) fwd_a = FWD_W;
    end
    fwd_b = FWD_RF;
    if (RA2E != PC_IDX) begin
      if (RegWriteM && (WA3M == RA2E))      fwd_b = FWD_M;
      else if (RegWriteW && (WA3W == RA2E)) fwd_b = FWD_W;
    end
  end

  assign ForwardAE  = fwd_a;
  assign ForwardBE  = fwd_b;
  assign ldr_stall  = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;

  // The timeout cycle releases the pipeline: the access is treated as complete.
  assign timeout  = (state_q == MS_WAIT) && !MemReadyM && (wait_cnt_q == WC_MAX);
  assign mem_wait = MemReqM && !MemReadyM && !timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MS_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // WAIT ignores MemReqM dropping; only ready or timeout ends the access.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      MS_IDLE: begin
        if (mem_wait) begin
          state_d    = MS_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MS_WAIT: begin
        if (MemReadyM || timeout) begin
          state_d    = MS_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = MS_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    MemErr = timeout;
    StallM = mem_wait;
    StallE = mem_wait;
    StallD = ldr_stall || mem_wait;
    StallF = ldr_stall || pc_wr_pend || mem_wait;
    FlushW = mem_wait;
    FlushE = (ldr_stall || BranchTakenE) && !mem_wait;
    FlushD = (pc_wr_pend || PCSrcW || BranchTakenE) && !mem_wait;
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .count (StallCount)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushD || FlushE),
    .count (FlushCount)
  );

endmodule

// File: doc/arm_hazard_unit.md
Name: arm_hazard_unit

Overview:
- Parametrised hazard controller for the five-stage pipelined ARM core (F, D, E, M, W).
- Generates operand forwarding selects for the Execute stage.
- Generates stall and flush controls for load-use hazards, PC writes and taken branches.
- Adds a data-memory wait handshake with timeout, plus saturating stall/flush performance counters.
- Sits beside the datapath; all hazard decisions for the core come from here.

Parameters:
- RA_W, 4, register-address width.
- PC_REG, 15, register index that is never forwarded (the PC).
- TIMEOUT, 16, maximum wait cycles for a memory request before an error is flagged.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- RA1D, RA2D  in  RA_W  source registers in Decode
- RA1E, RA2E  in  RA_W  source registers in Execute
- WA3E, WA3M, WA3W  in  RA_W  destination registers in E, M, W
- RegWriteM, RegWriteW  in  1  register write enables in M, W
- MemtoRegE  in  1  Execute-stage instruction is a load
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction writes the PC, per stage
- BranchTakenE  in  1  branch resolved taken in Execute
- MemReqM  in  1  Memory stage accesses dmem
- MemReadyM  in  1  dmem completes the access this cycle
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  insert a bubble into the corresponding register
- MemErr  out  1  one-cycle pulse when a memory access times out
- StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- Reset (asynchronous): FSM goes to IDLE; wait counter, StallCount and FlushCount go to 0; MemErr goes to 0.
- All other outputs are combinational and take their values from the current inputs and state.
- Forwarding, operand A (B is identical using RA2E):
  - 10 if RegWriteM && WA3M==RA1E && RA1E!=PC_REG.
  - Otherwise 01 if RegWriteW && WA3W==RA1E && RA1E!=PC_REG.
  - Otherwise 00. M has priority over W.
- ldrStall = MemtoRegE && (WA3E==RA1D || WA3E==RA2D).
- PCWrPend = PCSrcD || PCSrcE || PCSrcM.
- memWait = MemReqM && !MemReadyM && state is IDLE or WAIT, excluding the timeout cycle.
- Memory FSM states: IDLE and WAIT.
  - IDLE to WAIT when memWait; the wait counter loads 1.
  - WAIT to IDLE when MemReadyM.
  - WAIT increments the wait counter while not ready.
  - When the counter reaches TIMEOUT with no ready: pulse MemErr for 1 cycle, treat the access as complete, return to IDLE.
  - WAIT is held while MemReqM drops; the access is considered abandoned only on timeout.
- Stall and flush equations:
  - StallM = StallE = memWait.
  - StallD = ldrStall || memWait.
  - StallF = ldrStall || PCWrPend || memWait.
  - FlushW = memWait (bubble enters W while M holds).
  - FlushE = (ldrStall || BranchTakenE) && !memWait.
  - FlushD = (PCWrPend || PCSrcW || BranchTakenE) && !memWait.
- Priority: memWait freezes F through M and suppresses FlushD and FlushE, so no instruction is lost. Once memWait clears, any pending flush applies in the next cycle.
- Counters:
  - StallCount increments every cycle StallF is 1.
  - FlushCount increments every cycle FlushD or FlushE is 1.
  - Both saturate at all-ones and never wrap.
- Simultaneous ldrStall and BranchTakenE: the branch flush wins for E, and D still stalls. Harmless, because FlushD also applies.

Decomposition:
- Package arm_hazard_pkg holds:
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - enum mem_state_t {MS_IDLE, MS_WAIT};
  - default parameter constants.
- One sub-module, hz_sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Same with RA1E=15 -> ForwardAE=00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; FlushD=0.
- PCSrcD pulse propagating D to W -> StallF=1 for 3 cycles and FlushD=1 for 4 cycles; FlushCount ends at 4.
- MemReqM=1, MemReadyM low for 3 cycles then high -> StallF/D/E/M=1 and FlushW=1 for 3 cycles; FSM back in IDLE; StallCount=3.
- MemReqM=1 with MemReadyM never high, TIMEOUT=16 -> MemErr pulses once at the timeout cycle; stalls drop on the same cycle; FSM returns to IDLE.
- Assert reset mid-WAIT, asynchronously between clock edges -> state IDLE, counters 0, MemErr 0 immediately. Counter saturation: force 2^CNT_W-1 stall cycles and check StallCount holds at 0xFFFF.
